// File: rtl/rf_writeback_queue.sv
// In-order write-back buffer for the 32x32 register file.
// Retires one queued result per free write-port cycle; forwards queued values to decode.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_rd,
  input  logic [DW-1:0]          in_data,
  input  logic                   port_free,
  output logic                   WE3,
  output logic [AW-1:0]          A3,
  output logic [DW-1:0]          WD3,
  input  logic [AW-1:0]          q1_addr,
  input  logic [AW-1:0]          q2_addr,
  output logic                   q1_hit,
  output logic                   q2_hit,
  output logic [DW-1:0]          q1_data,
  output logic [DW-1:0]          q2_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] ent_rd   [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] idx;
  logic          push;
  logic          store;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign WE3      = !empty && port_free;
  assign pop      = WE3;
  assign in_ready = !full || WE3;
  assign push     = in_valid && in_ready;
  // x0 writes complete the handshake but never occupy a slot
  assign store    = push && (in_rd != '0);
  assign A3       = WE3 ? ent_rd[rd_ptr]   : '0;
  assign WD3      = WE3 ? ent_data[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      unique case ({store, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      ent_rd[wr_ptr]   <= in_rd;
      ent_data[wr_ptr] <= in_data;
    end
  end

  // Walk oldest to youngest so the youngest match overwrites earlier ones
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (q1_addr != '0 && ent_rd[idx] == q1_addr) begin
          q1_hit  = 1'b1;
          q1_data = ent_data[idx];
        end
        if (q2_addr != '0 && ent_rd[idx] == q2_addr) begin
          q2_hit  = 1'b1;
          q2_data = ent_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue.
// Vector table plus hand sequences for full, wrap and async reset.
module tb_rf_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        port_free;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  q1_addr;
  logic [4:0]  q2_addr;
  logic        q1_hit;
  logic        q2_hit;
  logic [31:0] q1_data;
  logic [31:0] q2_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data),
    .port_free(port_free),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .q1_addr(q1_addr), .q2_addr(q2_addr),
    .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_data(q1_data), .q2_data(q2_data),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        pf;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        rdy;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
    logic [2:0]  cnt;
    logic        fl;
    logic        em;
  } vec_t;

  vec_t vt [12];
  logic [36:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    q1_addr  = '0;
    q2_addr  = '0;
  endtask

  initial begin
    vt[0]  = '{0,0,0,1,0,0, 1,0,0,0, 0,0,0,0, 0,0,1};
    vt[1]  = '{1,3,32'hDEADBEEF,1,0,0, 1,0,0,0, 0,0,0,0, 0,0,1};
    vt[2]  = '{0,0,0,1,3,0, 1,1,3,32'hDEADBEEF, 1,32'hDEADBEEF,0,0, 1,0,0};
    vt[3]  = '{0,0,0,1,3,0, 1,0,0,0, 0,0,0,0, 0,0,1};
    vt[4]  = '{1,7,32'h11,0,7,0, 1,0,0,0, 0,0,0,0, 0,0,1};
    vt[5]  = '{1,7,32'h22,0,7,0, 1,0,0,0, 1,32'h11,0,0, 1,0,0};
    vt[6]  = '{0,0,0,0,7,5, 1,0,0,0, 1,32'h22,0,0, 2,0,0};
    vt[7]  = '{0,0,0,1,7,7, 1,1,7,32'h11, 1,32'h22,1,32'h22, 2,0,0};
    vt[8]  = '{0,0,0,1,7,0, 1,1,7,32'h22, 1,32'h22,0,0, 1,0,0};
    vt[9]  = '{0,0,0,1,7,0, 1,0,0,0, 0,0,0,0, 0,0,1};
    vt[10] = '{1,0,32'hFFFFFFFF,1,0,0, 1,0,0,0, 0,0,0,0, 0,0,1};
    vt[11] = '{0,0,0,1,0,0, 1,0,0,0, 0,0,0,0, 0,0,1};

    rst_n     = 1'b0;
    port_free = 1'b1;
    idle();
    #1;
    chk("rst_we", WE3, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd", WD3, 0);
    chk("rst_cnt", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_hit", {q1_hit, q2_hit}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      in_valid  = vt[i].v;
      in_rd     = vt[i].rd;
      in_data   = vt[i].d;
      port_free = vt[i].pf;
      q1_addr   = vt[i].a1;
      q2_addr   = vt[i].a2;
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, vt[i].rdy);
      chk($sformatf("v%0d_we", i), WE3, vt[i].we);
      chk($sformatf("v%0d_a3", i), A3, vt[i].a3);
      chk($sformatf("v%0d_wd", i), WD3, vt[i].wd);
      chk($sformatf("v%0d_h1", i), q1_hit, vt[i].h1);
      chk($sformatf("v%0d_d1", i), q1_data, vt[i].d1);
      chk($sformatf("v%0d_h2", i), q2_hit, vt[i].h2);
      chk($sformatf("v%0d_d2", i), q2_data, vt[i].d2);
      chk($sformatf("v%0d_cnt", i), count, vt[i].cnt);
      chk($sformatf("v%0d_full", i), full, vt[i].fl);
      chk($sformatf("v%0d_empty", i), empty, vt[i].em);
      step();
    end

    // Fill with the port blocked, fifth push stalls until a pop frees a slot
    idle();
    port_free = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_rd    = 5'(i);
      in_data  = 32'h100 + 32'(i);
      #1;
      chk($sformatf("fill%0d_ready", i), in_ready, (i <= 4));
      chk($sformatf("fill%0d_we", i), WE3, 0);
      if (i <= 4) step();
    end
    chk("fill_full", full, 1);
    chk("fill_cnt", count, 4);
    port_free = 1'b1;
    #1;
    chk("fill5_ready_pop", in_ready, 1);
    chk("fill_pop1_we", WE3, 1);
    chk("fill_pop1_a3", A3, 1);
    chk("fill_pop1_wd", WD3, 32'h101);
    step();
    in_valid = 1'b0;
    for (int j = 2; j <= 5; j++) begin
      #1;
      chk($sformatf("fill_pop%0d_we", j), WE3, 1);
      chk($sformatf("fill_pop%0d_a3", j), A3, j);
      chk($sformatf("fill_pop%0d_wd", j), WD3, 32'h100 + 32'(j));
      step();
    end
    #1;
    chk("fill_drained", empty, 1);

    // Full queue with simultaneous push and pop across the pointer wrap
    port_free = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_rd    = 5'(8 + i);
      in_data  = 32'hB000_0000 + 32'(i);
      exp_q.push_back({in_rd, in_data});
      step();
    end
    port_free = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_rd    = 5'((i % 30) + 1);
      in_data  = 32'hA000_0000 + 32'(i * 3);
      #1;
      chk($sformatf("wrap%0d_cnt", i), count, 4);
      chk($sformatf("wrap%0d_ready", i), in_ready, 1);
      chk($sformatf("wrap%0d_we", i), WE3, 1);
      chk($sformatf("wrap%0d_wr", i), {A3, WD3}, exp_q[0]);
      void'(exp_q.pop_front());
      exp_q.push_back({in_rd, in_data});
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wdrain%0d_we", i), WE3, 1);
      chk($sformatf("wdrain%0d_wr", i), {A3, WD3}, exp_q[0]);
      void'(exp_q.pop_front());
      step();
    end
    #1;
    chk("wrap_empty", empty, 1);

    // Asynchronous reset between edges discards queued entries
    port_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_rd    = 5'(20 + i);
      in_data  = 32'hC000_0000 + 32'(i);
      step();
    end
    in_valid  = 1'b0;
    port_free = 1'b1;
    #1;
    chk("ar_pre_cnt", count, 3);
    chk("ar_pre_we", WE3, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_we", WE3, 0);
    chk("ar_cnt", count, 0);
    chk("ar_empty", empty, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("ar_post%0d_we", i), WE3, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Write-side companion of the 32x32 register file (two combinational read ports, one synchronous write port WE3/A3/WD3, x0 hard-wired to zero). It buffers destination-register results from the execute/memory stages in a small in-order FIFO and retires them into the register file's single write port, one write per cycle, whenever that port is free. It also gives the decode stage a forwarding lookup, so reads can see results that are still queued and have not yet reached the register file.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  rising-edge clock shared with the register file
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer offers a result
- in_ready  out  1  queue accepts this cycle
- in_rd  in  AW  destination register
- in_data  in  DW  result value
- port_free  in  1  register-file write port is available this cycle
- WE3  out  1  write enable to the register file
- A3  out  AW  write address to the register file
- WD3  out  DW  write data to the register file
- q1_addr, q2_addr  in  AW  forwarding lookup addresses (the register file's A1/A2)
- q1_hit, q2_hit  out  1  a queued entry matches the lookup address
- q1_data, q2_data  out  DW  data of the youngest matching entry
- count  out  log2(DEPTH)+1  occupancy
- full, empty  out  1  occupancy flags

## Operation
- Circular FIFO with rd_ptr, wr_ptr and count. Each entry holds {rd, data}.
- Push happens when in_valid & in_ready. If in_rd == 0, the handshake completes but nothing is stored (x0 writes are discarded).
- Pop happens when WE3 is high. WE3 = !empty & port_free. A3/WD3 = head entry. When WE3 = 0, A3 and WD3 are driven to 0.
- in_ready = !full | WE3, so a push is accepted while full if a pop happens in the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance, wrapping modulo DEPTH.
- Forwarding lookup is combinational over all valid entries, including the head being written this cycle.
  - If several entries match, the youngest (closest to wr_ptr) wins.
  - Address 0 never hits; hit = 0 forces data = 0.
  - The value currently on in_* is not visible to lookups until it is stored.
- No coalescing: repeated writes to the same rd are each retired, in order.
- Ordering: register-file writes occur in exact acceptance order.

## Timing
- Reset (asynchronous assert, synchronous-safe release) gives: pointers = 0, count = 0, empty = 1, full = 0, in_ready = 1, WE3 = 0, A3 = 0, WD3 = 0, q*_hit = 0, q*_data = 0.
- Reset asserted mid-operation discards every queued entry; none of them is written.
- Latency: an entry accepted at edge N can first drive WE3 in cycle N+1, with the register-file write at edge N+1. There is no same-cycle bypass from in_* to WE3.
- Lookup hits reflect queue contents after edge N, throughout cycle N+1.
- Throughput: one push and one pop per cycle are sustained indefinitely when port_free = 1.
- port_free low: the head holds and WE3 = 0. Once the queue is full, in_ready = 0 until port_free returns.
- count, full and empty are registered-state derived and stable all cycle. in_ready and WE3 depend combinationally on port_free.

## Test plan
- Reset, then push {rd=3, data=0xDEADBEEF} with port_free = 1. Required: WE3 = 1, A3 = 3, WD3 = 0xDEADBEEF exactly one cycle later; count returns to 0 after that edge.
- Hold port_free = 0 and push rd = 1, 2, 3, 4, 5. Required: 4 accepted, full = 1, in_ready = 0 on the 5th. Then raise port_free. Required: writes retire in order 1, 2, 3, 4, and the 5th is accepted in the first pop cycle.
- Queue {rd=7, 0x11} then {rd=7, 0x22} with port_free = 0, and set q1_addr = 7. Required: q1_hit = 1, q1_data = 0x22. After the first pop, q1_data is still 0x22; after both pops, q1_hit = 0.
- Push rd = 0 with data 0xFFFFFFFF. Required: in_ready = 1, count stays 0, WE3 never asserts; q1_addr = 0 gives q1_hit = 0.
- Run a full queue with continuous push and pop for 20 cycles across the pointer wrap. Required: count stays DEPTH, and the write sequence equals the push sequence.
- Assert rst_n low asynchronously (between edges) with 3 entries queued. Required: WE3 = 0 and count = 0 immediately; none of the 3 entries is ever written after release.
